zet_pic: RTL and testbench
==========================

ZET_PIC -- requirements
Module: zet_pic

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 The port clk SHALL be an input, 1 bit wide, carrying the system clock; all state changes on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, providing synchronous active-high reset.
REQ-004 The port irq SHALL be an input, 8 bits wide, carrying the interrupt request lines, with bit 0 as the highest priority; these lines are already synchronous to clk.
REQ-005 The port intr SHALL be an output, 1 bit wide, carrying the interrupt request to the core.
REQ-006 The port inta SHALL be an input, 1 bit wide, carrying the acknowledge from the core; the PIC acts on its rising edge only.
REQ-007 The port iid_dat_o SHALL be an output, 16 bits wide, carrying the interrupt vector presented to the core as {8'h00, vector}.
REQ-008 The port io_stb SHALL be an input, 1 bit wide, acting as the I/O access strobe and held until io_ack.
REQ-009 The port io_we SHALL be an input, 1 bit wide: 1 selects write, 0 selects read.
REQ-010 The port io_adr SHALL be an input, 1 bit wide, selecting port 0 (command) or port 1 (data).
REQ-011 The port io_dat_i SHALL be an input, 8 bits wide, carrying I/O write data.
REQ-012 The port io_dat_o SHALL be an output, 8 bits wide, carrying I/O read data, valid while io_ack=1.
REQ-013 The port io_ack SHALL be an output, 1 bit wide, producing a single-cycle access acknowledge.

Function
REQ-014 Registers SHALL comprise IRR[7:0], ISR[7:0], IMR[7:0], vector base VB[4:0], the read-select flag RIS, the vector latch VEC[7:0], the config state CS with values READY and ICW2, inta_q, and irq_q[7:0].
REQ-015 Request latching SHALL set IRR[n] when irq[n] & ~irq_q[n]; this is edge-triggered, and a line held high does not re-set IRR.
REQ-016 Priority SHALL be fixed, with 0 highest; P is the lowest index with (IRR & ~IMR)[n]=1.
REQ-017 intr SHALL be registered and equal 1 iff P exists and no ISR bit with index <= P is set (fully nested).
REQ-018 An acknowledge SHALL be recognised on the cycle where inta & ~inta_q, and the next edge SHALL then perform: if P exists, IRR[P]<=0, ISR[P]<=1, and VEC<={VB,P[2:0]}.
REQ-019 If no unmasked request is pending at acknowledge (spurious), VEC SHALL be set to {VB,3'd7}, and IRR and ISR SHALL be unchanged.
REQ-020 iid_dat_o SHALL be driven from VEC and hold its value until the next acknowledge.
REQ-021 intr SHALL drop on the cycle after the acknowledge update, unless a higher-priority request remains eligible.
REQ-022 An I/O access SHALL produce io_ack=1 exactly one cycle after io_stb is first sampled high, and io_ack=0 in the following cycle; a write takes effect on the ack cycle.
REQ-023 A port 0 write with bit4=1 (ICW1) SHALL set CS<=ICW2, IMR<=8'h00, ISR<=8'h00, and RIS<=0.
REQ-024 A port 1 write while CS=ICW2 SHALL set VB<=io_dat_i[7:3] and CS<=READY.
REQ-025 A port 1 write while CS=READY SHALL set IMR<=io_dat_i.
REQ-026 A port 0 write of 8'h20 (non-specific EOI) SHALL clear the lowest-index set ISR bit, or do nothing if ISR=0.
REQ-027 A port 0 write of 8'b01100nnn (specific EOI) SHALL clear ISR[nnn].
REQ-028 A port 0 write of 8'h0A SHALL set RIS<=0, and a write of 8'h0B SHALL set RIS<=1; all other port 0 values with bit4=0 SHALL be ignored.
REQ-029 Port 0 reads SHALL return IRR when RIS=0 and ISR when RIS=1; port 1 reads SHALL return IMR.
REQ-030 Simultaneous events SHALL resolve as follows.
- New irq edge on line P in the acknowledge cycle: the set wins and IRR[P] stays 1.
- EOI write in the acknowledge cycle: the EOI clear applies first, then the acknowledge ISR set.
- ICW1 in the acknowledge cycle: ICW1 wins and the ISR set is discarded; VEC still updates.
REQ-031 Masking SHALL NOT clear IRR, and unmasking a pending bit SHALL raise intr on the next cycle if it is not blocked by ISR.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL set IRR=0, ISR=0, IMR=8'hFF, VB=5'b00001, VEC=8'h08, RIS=0, CS=READY, inta_q=0, irq_q=0, intr=0, io_ack=0, io_dat_o=0, and iid_dat_o=16'h0008.
REQ-033 Reset asserted mid-access or mid-acknowledge SHALL abort the operation with no register update, and io_ack SHALL be 0 in the cycle following reset.

Verification
REQ-034 Reset, then read port 1 and port 0 -> 8'hFF and 8'h00; intr=0; iid_dat_o=16'h0008.
REQ-035 Write port 0 8'h11, port 1 8'h20, port 1 8'hFC, then pulse irq[3] -> intr=0 (masked); then write port 1 8'hF4 -> intr=1; then pulse inta -> iid_dat_o=16'h0023, ISR=8'h08, intr=0.
REQ-036 With ISR[3] set, edges on irq[5] and irq[1] -> intr=1 for irq1; after acknowledge, vector=8'h21 and ISR=8'h0A; non-specific EOI 8'h20 -> ISR=8'h08; acknowledge for irq5 is blocked (intr=0) until 8'h63 is written -> then intr=1.
REQ-037 Pulse inta with IRR & ~IMR=0 -> iid_dat_o={VB,3'd7} (8'h27 with VB=5'b00100); ISR unchanged.
REQ-038 Drive an irq[2] edge in the same cycle as the acknowledge of pending irq[2] -> ISR[2]=1, IRR[2]=1, intr stays 0 until EOI 8'h62, then rises.
REQ-039 Assert rst during an io_stb write to IMR and during an inta edge -> all registers hold reset values; io_ack=0.

Source files
------------

// File: rtl/zet_pic.sv
// 8-line fixed-priority interrupt controller with a two-port I/O register map.
// Edge-triggered requests, fully nested in-service masking, vector latched on the inta rising edge.
module zet_pic (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  irq,
    output logic        intr,
    input  logic        inta,
    output logic [15:0] iid_dat_o,
    input  logic        io_stb,
    input  logic        io_we,
    input  logic        io_adr,
    input  logic [7:0]  io_dat_i,
    output logic [7:0]  io_dat_o,
    output logic        io_ack
);

    typedef enum logic {CS_READY = 1'b0, CS_ICW2 = 1'b1} cs_t;

    cs_t        cs, cs_next;
    logic [7:0] irr, isr, imr, vec;
    logic [4:0] vb;
    logic       ris;
    logic       inta_q;
    logic [7:0] irq_q;

    function automatic logic [7:0] lowest_bit(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    function automatic logic [2:0] bit_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) idx = 3'(i);
        return idx;
    endfunction

    // Mask of every line whose priority is equal to or higher than line p.
    function automatic logic [7:0] prio_at_or_above(input logic [2:0] p);
        return (8'd2 << p) - 8'd1;
    endfunction

    logic [7:0] pend, p_onehot, ack_set, eoi_clr, irq_edge;
    logic [2:0] p_idx;
    logic       p_valid, blocked, ack;
    logic       acc, rd, wr_cmd, wr_dat;
    logic       icw1, ns_eoi, sp_eoi, ris_clr, ris_set;
    logic       vb_we, imr_we;

    assign pend     = irr & ~imr;
    assign p_valid  = |pend;
    assign p_onehot = lowest_bit(pend);
    assign p_idx    = bit_index(pend);
    assign blocked  = |(isr & prio_at_or_above(p_idx));
    assign ack      = inta & ~inta_q;
    assign ack_set  = (ack && p_valid) ? p_onehot : 8'h00;
    assign irq_edge = irq & ~irq_q;

    // An access is serviced on the first sampled strobe; the ack cycle masks a lingering strobe.
    assign acc    = io_stb & ~io_ack;
    assign rd     = acc & ~io_we;
    assign wr_cmd = acc & io_we & ~io_adr;
    assign wr_dat = acc & io_we & io_adr;

    assign icw1    = wr_cmd & io_dat_i[4];
    assign ns_eoi  = wr_cmd & (io_dat_i == 8'h20);
    assign sp_eoi  = wr_cmd & (io_dat_i[7:3] == 5'b01100);
    assign ris_clr = wr_cmd & (io_dat_i == 8'h0A);
    assign ris_set = wr_cmd & (io_dat_i == 8'h0B);

    always_comb begin
        eoi_clr = 8'h00;
        if (ns_eoi)
            eoi_clr = lowest_bit(isr);
        else if (sp_eoi)
            eoi_clr = 8'd1 << io_dat_i[2:0];
    end

    always_ff @(posedge clk) begin
        if (rst) cs <= CS_READY;
        else     cs <= cs_next;
    end

    always_comb begin
        cs_next = cs;
        if (icw1)
            cs_next = CS_ICW2;
        else if (wr_dat && cs == CS_ICW2)
            cs_next = CS_READY;
    end

    always_comb begin
        vb_we  = 1'b0;
        imr_we = 1'b0;
        if (wr_dat) begin
            if (cs == CS_ICW2) vb_we  = 1'b1;
            else               imr_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irr      <= 8'h00;
            isr      <= 8'h00;
            imr      <= 8'hFF;
            vb       <= 5'b00001;
            vec      <= 8'h08;
            ris      <= 1'b0;
            inta_q   <= 1'b0;
            irq_q    <= 8'h00;
            intr     <= 1'b0;
            io_ack   <= 1'b0;
            io_dat_o <= 8'h00;
        end else begin
            irq_q  <= irq;
            inta_q <= inta;
            io_ack <= acc;
            // A fresh edge on the line being acknowledged keeps it pending.
            irr    <= (irr & ~ack_set) | irq_edge;
            if (icw1) begin
                isr <= 8'h00;
                imr <= 8'h00;
                ris <= 1'b0;
            end else begin
                isr <= (isr & ~eoi_clr) | ack_set;
                if (imr_we)       imr <= io_dat_i;
                if (ris_clr)      ris <= 1'b0;
                else if (ris_set) ris <= 1'b1;
            end
            if (vb_we) vb <= io_dat_i[7:3];
            if (ack)   vec <= {vb, p_valid ? p_idx : 3'd7};
            if (rd)    io_dat_o <= io_adr ? imr : (ris ? isr : irr);
            intr <= p_valid & ~blocked;
        end
    end

    assign iid_dat_o = {8'h00, vec};

endmodule

// File: tb/tb_zet_pic.sv
// Scoreboarded bench for zet_pic: directed scenarios followed by randomized traffic,
// checked every cycle against a behavioural model of the controller.
module tb_zet_pic;

    logic        clk, rst;
    logic [7:0]  irq;
    logic        intr, inta;
    logic [15:0] iid_dat_o;
    logic        io_stb, io_we, io_adr;
    logic [7:0]  io_dat_i, io_dat_o;
    logic        io_ack;

    zet_pic dut (
        .clk(clk), .rst(rst), .irq(irq), .intr(intr), .inta(inta),
        .iid_dat_o(iid_dat_o), .io_stb(io_stb), .io_we(io_we), .io_adr(io_adr),
        .io_dat_i(io_dat_i), .io_dat_o(io_dat_o), .io_ack(io_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    typedef struct { bit rd; logic [7:0] d; } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: request/priority/nesting rules evaluated with plain loops per clock.
    logic [7:0] m_irr, m_isr, m_imr, m_vec, m_irq_q;
    logic [4:0] m_vb;
    bit         m_ris, m_icw2, m_inta_q, m_intr, m_ack;

    always @(posedge clk) begin
        int p;
        bit blk, acc, ack, wcmd;
        logic [7:0] nirr, nisr, nimr, nvec;
        logic [4:0] nvb;
        bit nris, nicw2;
        if (rst) begin
            m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF; m_vb = 5'd1; m_vec = 8'h08;
            m_ris = 0; m_icw2 = 0; m_inta_q = 0; m_irq_q = 8'h00; m_intr = 0; m_ack = 0;
        end else begin
            p = -1;
            for (int i = 7; i >= 0; i--)
                if (m_irr[i] && !m_imr[i]) p = i;
            blk = 0;
            for (int i = 0; i < 8; i++)
                if (i <= p && m_isr[i]) blk = 1;
            acc = io_stb && !m_ack;
            ack = inta && !m_inta_q;
            nirr = m_irr; nisr = m_isr; nimr = m_imr; nvec = m_vec; nvb = m_vb;
            nris = m_ris; nicw2 = m_icw2;
            if (acc && !io_we)
                exp_q.push_back('{1'b1, io_adr ? m_imr : (m_ris ? m_isr : m_irr)});
            else if (acc)
                exp_q.push_back('{1'b0, 8'h00});
            if (ack && p >= 0) nirr[p] = 1'b0;
            for (int i = 0; i < 8; i++)
                if (irq[i] && !m_irq_q[i]) nirr[i] = 1'b1;
            wcmd = acc && io_we && !io_adr;
            if (wcmd && !io_dat_i[4]) begin
                if (io_dat_i == 8'h20) begin
                    for (int i = 0; i < 8; i++)
                        if (nisr[i]) begin nisr[i] = 1'b0; break; end
                end else if (io_dat_i >= 8'h60 && io_dat_i <= 8'h67)
                    nisr[io_dat_i - 8'h60] = 1'b0;
                else if (io_dat_i == 8'h0A) nris = 0;
                else if (io_dat_i == 8'h0B) nris = 1;
            end
            if (acc && io_we && io_adr) begin
                if (m_icw2) begin nvb = io_dat_i[7:3]; nicw2 = 0; end
                else nimr = io_dat_i;
            end
            if (ack && p >= 0) nisr[p] = 1'b1;
            if (wcmd && io_dat_i[4]) begin
                nisr = 8'h00; nimr = 8'h00; nris = 0; nicw2 = 1;
            end
            if (ack) nvec = m_vb * 8 + ((p >= 0) ? p : 7);
            m_intr = (p >= 0) && !blk;
            m_ack = acc; m_inta_q = inta; m_irq_q = irq;
            m_irr = nirr; m_isr = nisr; m_imr = nimr; m_vec = nvec; m_vb = nvb;
            m_ris = nris; m_icw2 = nicw2;
        end
    end

    // Monitor: compares DUT outputs with the model and pops the access scoreboard on io_ack.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            check("intr", 16'(intr), 16'(m_intr));
            check("iid_dat_o", iid_dat_o, {8'h00, m_vec});
            check("io_ack", 16'(io_ack), 16'(m_ack));
            if (io_ack) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL io_ack_unexpected: got ack with empty scoreboard at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (e.rd) check("io_dat_o", 16'(io_dat_o), 16'(e.d));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_xfer(input logic we, input logic adr, input logic [7:0] d, output logic [7:0] rdat);
        int n;
        tick(1);
        io_stb = 1; io_we = we; io_adr = adr; io_dat_i = d;
        n = 0;
        do begin tick(1); n++; end while (!io_ack && n < 8);
        if (!io_ack) begin
            n_vec++; n_err++;
            $display("FAIL io_ack_timeout: got no ack expected ack within 8 cycles at %0t", $time);
        end
        rdat = io_dat_o;
        io_stb = 0; io_we = 0;
    endtask

    task automatic wr(input logic adr, input logic [7:0] d);
        logic [7:0] dummy;
        io_xfer(1'b1, adr, d, dummy);
    endtask

    task automatic rd_check(input string name, input logic adr, input logic [7:0] exp);
        logic [7:0] r;
        io_xfer(1'b0, adr, 8'h00, r);
        check(name, 16'(r), 16'(exp));
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        tick(1); irq = m;
        tick(1); irq = 8'h00;
    endtask

    task automatic pulse_inta(input logic [7:0] m);
        tick(1); inta = 1; irq = m;
        tick(1); inta = 0; irq = 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        rst = 1; irq = 0; inta = 0; io_stb = 0; io_we = 0; io_adr = 0; io_dat_i = 0;
        tick(1);
        started = 1;
        tick(2);
        rst = 0;
        check("rst_intr", 16'(intr), 16'h0000);
        check("rst_iid", iid_dat_o, 16'h0008);
        check("rst_io_dat_o", 16'(io_dat_o), 16'h0000);
        check("rst_io_ack", 16'(io_ack), 16'h0000);
        rd_check("rst_imr", 1'b1, 8'hFF);
        rd_check("rst_irr", 1'b0, 8'h00);

        // Init sequence, masked request, then unmask and acknowledge.
        wr(0, 8'h11); wr(1, 8'h20); wr(1, 8'hFC);
        pulse_irq(8'h08);
        tick(3);
        check("masked_intr", 16'(intr), 16'h0000);
        wr(1, 8'hF4);
        tick(2);
        check("unmask_intr", 16'(intr), 16'h0001);
        pulse_inta(8'h00);
        tick(2);
        check("ack3_iid", iid_dat_o, 16'h0023);
        check("ack3_intr", 16'(intr), 16'h0000);
        wr(0, 8'h0B);
        rd_check("ack3_isr", 1'b0, 8'h08);

        // Nesting: irq1 preempts in-service irq3, irq5 stays blocked until irq3 is cleared.
        wr(1, 8'h00);
        pulse_irq(8'h22);
        tick(2);
        check("nest_intr1", 16'(intr), 16'h0001);
        pulse_inta(8'h00);
        tick(2);
        check("ack1_iid", iid_dat_o, 16'h0021);
        rd_check("ack1_isr", 1'b0, 8'h0A);
        wr(0, 8'h20);
        rd_check("nseoi_isr", 1'b0, 8'h08);
        tick(2);
        check("irq5_blocked", 16'(intr), 16'h0000);
        wr(0, 8'h63);
        tick(2);
        check("irq5_unblocked", 16'(intr), 16'h0001);
        pulse_inta(8'h00);
        tick(2);
        check("ack5_iid", iid_dat_o, 16'h0025);

        // Spurious acknowledge leaves ISR alone and returns vector 7.
        pulse_inta(8'h00);
        tick(2);
        check("spurious_iid", iid_dat_o, 16'h0027);
        rd_check("spurious_isr", 1'b0, 8'h20);
        wr(0, 8'h65);

        // Re-request on the same line during its acknowledge.
        pulse_irq(8'h04);
        tick(2);
        pulse_inta(8'h04);
        tick(2);
        check("reirq_intr", 16'(intr), 16'h0000);
        rd_check("reirq_isr", 1'b0, 8'h04);
        wr(0, 8'h0A);
        rd_check("reirq_irr", 1'b0, 8'h04);
        wr(0, 8'h62);
        tick(2);
        check("reirq_eoi_intr", 16'(intr), 16'h0001);
        pulse_inta(8'h00);
        wr(0, 8'h20);

        // Randomized traffic; the model and monitor carry the checking.
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 7))
                0: pulse_irq(8'($urandom & $urandom));
                1: pulse_inta(8'($urandom & $urandom & $urandom));
                2: wr(1, 8'($urandom & $urandom));
                3: wr(0, 8'h20);
                4: wr(0, 8'h60 | 8'($urandom_range(0, 7)));
                5: wr(0, ($urandom_range(0, 1) != 0) ? 8'h0B : 8'h0A);
                6: begin
                    logic [7:0] r;
                    io_xfer(1'b0, 1'($urandom_range(0, 1)), 8'h00, r);
                end
                default: if ($urandom_range(0, 9) == 0) wr(0, 8'h11); else tick(1);
            endcase
        end

        // Reset in the middle of an IMR write and an acknowledge edge.
        pulse_irq(8'h01);
        tick(1);
        rst = 1; io_stb = 1; io_we = 1; io_adr = 1; io_dat_i = 8'h55; inta = 1;
        tick(1);
        rst = 0; io_stb = 0; io_we = 0; inta = 0;
        check("rst_mid_io_ack", 16'(io_ack), 16'h0000);
        check("rst_mid_iid", iid_dat_o, 16'h0008);
        check("rst_mid_intr", 16'(intr), 16'h0000);
        rd_check("rst_mid_imr", 1'b1, 8'hFF);
        rd_check("rst_mid_irr", 1'b0, 8'h00);
        wr(0, 8'h0B);
        rd_check("rst_mid_isr", 1'b0, 8'h00);
        tick(3);

        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
